axi4_lite_regfile: RTL and testbench
====================================

AXI4_LITE_REGFILE -- requirements
Module: axi4_lite_regfile

Interface
REQ-001 SHALL have parameter DATA_W, default 32, AXI data width; legal values 32 or 64.
REQ-002 SHALL have parameter ADDR_W, default 12, AXI byte-address width.
REQ-003 SHALL have parameter NUM_REGS, default 16, register count; NUM_REGS*DATA_W/8 <= 2**ADDR_W.
REQ-004 SHALL have parameter RO_MASK, default all-zero NUM_REGS bits; bit i=1 makes register i read-only, sourced from ro_in.
REQ-005 SHALL use one clock and an asynchronous, active-low reset: aclk  input  1  clock, rising edge.
REQ-006 aresetn  input  1  asynchronous active-low reset.
REQ-007 S_AXI_AWADDR/AWPROT/AWVALID in, AWREADY out  ADDR_W/3/1/1  write-address channel; AWPROT ignored.
REQ-008 S_AXI_WDATA/WSTRB/WVALID in, WREADY out  DATA_W/DATA_W/8/1/1  write-data channel.
REQ-009 S_AXI_BRESP/BVALID out, BREADY in  2/1/1  write-response channel.
REQ-010 S_AXI_ARADDR/ARPROT/ARVALID in, ARREADY out  ADDR_W/3/1/1  read-address channel; ARPROT ignored.
REQ-011 S_AXI_RDATA/RRESP/RVALID out, RREADY in  DATA_W/2/1/1  read-data channel.
REQ-012 reg_q  output  NUM_REGS*DATA_W  current RW register contents, register i at bits [i*DATA_W +: DATA_W]; RO slots drive 0.
REQ-013 ro_in  input  NUM_REGS*DATA_W  hardware values returned for RO registers; same slot layout as reg_q.
REQ-014 wr_pulse  output  1  one-cycle strobe on each committed RW write; wr_idx  output  clog2(NUM_REGS)  index of that write.

Function
REQ-015 Register index SHALL be addr >> log2(DATA_W/8); the low byte-offset bits are ignored.
REQ-016 An index >= NUM_REGS SHALL be out of range: response SLVERR (2'b10), no state change, RDATA=0.
REQ-017 A write to a RO index SHALL return SLVERR and SHALL NOT change any state or pulse wr_pulse.
REQ-018 The write FSM SHALL have states W_IDLE, W_HAVE_AW, W_HAVE_W and W_RESP.
REQ-019 AW and W SHALL be accepted independently in either order, or in the same cycle, each into a one-deep holding register.
REQ-020 AWREADY SHALL be high only in W_IDLE and W_HAVE_W; WREADY SHALL be high only in W_IDLE and W_HAVE_AW.
REQ-021 The commit SHALL occur on the first edge at which both address and data are held.
REQ-022 BVALID SHALL rise the cycle after both handshakes complete; W_IDLE->W_RESP directly when AW and W handshake together.
REQ-023 The committed write SHALL update only the bytes with WSTRB set; a WSTRB of 0 is OKAY with no data change but still pulses wr_pulse.
REQ-024 BVALID and BRESP SHALL hold stable until BREADY; the FSM returns to W_IDLE on the BVALID&&BREADY edge.
REQ-025 The read FSM SHALL have states R_IDLE and R_RESP; ARREADY is high only in R_IDLE.
REQ-026 On an AR handshake, RDATA/RRESP SHALL register the pre-edge register value (RW) or ro_in (RO), with RVALID high next cycle.
REQ-027 RVALID, RDATA and RRESP SHALL hold stable until RREADY; the FSM returns to R_IDLE on the handshake.
REQ-028 Read and write paths SHALL be fully concurrent; a read sampled on the same edge as a write commit to the same index returns the old value.
REQ-029 Maximum throughput SHALL be one transaction every 2 cycles per channel.

Reset
REQ-030 While aresetn=0, all outputs SHALL be 0: READY/VALID signals, BRESP, RRESP, RDATA, reg_q, wr_pulse, wr_idx.
REQ-031 Reset SHALL return both FSMs to IDLE and discard held AW/W and pending responses, even mid-transaction.
REQ-032 Release SHALL be synchronised internally; the first READY may assert on the second aclk edge after deassertion.

Structure
REQ-033 Package axi4_lite_pkg SHALL hold resp_t with RESP_OKAY=2'b00 and RESP_SLVERR=2'b10, plus the write-FSM and read-FSM state enums.
REQ-034 Sub-module axi4_lite_wstrb_merge SHALL perform the combinational byte-enable merge (old, new, strb -> merged).

Verification
REQ-035 AW then W three cycles later, addr 0x8, WDATA 0xDEADBEEF, WSTRB 0xF -> BVALID one cycle after W handshake, BRESP=0, reg_q slot 2 = 0xDEADBEEF, wr_pulse with wr_idx=2.
REQ-036 Reg 1 = 0x11223344, then write addr 0x4, WDATA 0xAABBCCDD, WSTRB 0x5 -> reg 1 = 0x11BB33DD.
REQ-037 Read addr 0x40 with NUM_REGS=16 -> RRESP=2'b10, RDATA=0; write to addr 0x40 -> BRESP=2'b10, no wr_pulse.
REQ-038 RO_MASK bit 3 set, ro_in slot 3 = 0xCAFE0001 -> read 0xC returns 0xCAFE0001 OKAY; write 0xC returns SLVERR.
REQ-039 Read reg 5 on the same edge as a commit of 0x0000FFFF to reg 5 (old 0) -> RDATA=0; a following read returns 0x0000FFFF.
REQ-040 BREADY held low for 10 cycles -> BVALID/BRESP stable and AWREADY=WREADY=0; aresetn pulse mid-hold -> all outputs 0, FSMs IDLE.

Source files
------------

// File: rtl/axi4_lite_pkg.sv
// Shared types for the AXI4-Lite register file: response codes and the
// write/read channel state encodings, plus a small response helper.
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_HAVE_AW = 2'd1,
    W_HAVE_W  = 2'd2,
    W_RESP    = 2'd3
  } wstate_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } rstate_t;

  // Map an access-legal flag onto the AXI response code.
  function automatic resp_t ok_resp(input logic ok);
    return ok ? RESP_OKAY : RESP_SLVERR;
  endfunction

endpackage

// File: rtl/axi4_lite_wstrb_merge.sv
// Byte-enable merge: each byte of the result comes from i_new when its strobe
// bit is set, otherwise from i_old.
//   i_old      : current register contents
//   i_new      : write data
//   i_strb     : byte strobes, bit b covers bits [8b+7:8b]
//   o_merged_c : merged word (combinational)
module axi4_lite_wstrb_merge
  import axi4_lite_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0]   i_old,
  input  logic [DATA_W-1:0]   i_new,
  input  logic [DATA_W/8-1:0] i_strb,
  output logic [DATA_W-1:0]   o_merged_c
);

  localparam int unsigned STRB_W = DATA_W / 8;

  always_comb begin
    o_merged_c = i_old;
    for (int b = 0; b < STRB_W; b++) begin
      if (i_strb[b]) o_merged_c[b*8 +: 8] = i_new[b*8 +: 8];
    end
  end

endmodule

// File: rtl/axi4_lite_regfile.sv
// AXI4-Lite slave exposing NUM_REGS registers of DATA_W bits. Registers flagged
// in RO_MASK are read-only and return ro_in; the rest are RW with byte strobes.
// Ports:
//   aclk, aresetn        : clock, async active-low reset (release synchronised)
//   S_AXI_AW* / W* / B*  : write address, data and response channels
//   S_AXI_AR* / R*       : read address and data channels
//   reg_q                : packed RW register contents (RO slots read as 0)
//   ro_in                : packed hardware values for RO registers
//   wr_pulse, wr_idx     : one-cycle strobe and index of each committed RW write
module axi4_lite_regfile
  import axi4_lite_pkg::*;
#(
  parameter int unsigned          DATA_W   = 32,
  parameter int unsigned          ADDR_W   = 12,
  parameter int unsigned          NUM_REGS = 16,
  parameter logic [NUM_REGS-1:0]  RO_MASK  = '0
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [ADDR_W-1:0]            S_AXI_AWADDR,
  input  logic [2:0]                   S_AXI_AWPROT,
  input  logic                         S_AXI_AWVALID,
  output logic                         S_AXI_AWREADY,
  input  logic [DATA_W-1:0]            S_AXI_WDATA,
  input  logic [DATA_W/8-1:0]          S_AXI_WSTRB,
  input  logic                         S_AXI_WVALID,
  output logic                         S_AXI_WREADY,
  output logic [1:0]                   S_AXI_BRESP,
  output logic                         S_AXI_BVALID,
  input  logic                         S_AXI_BREADY,
  input  logic [ADDR_W-1:0]            S_AXI_ARADDR,
  input  logic [2:0]                   S_AXI_ARPROT,
  input  logic                         S_AXI_ARVALID,
  output logic                         S_AXI_ARREADY,
  output logic [DATA_W-1:0]            S_AXI_RDATA,
  output logic [1:0]                   S_AXI_RRESP,
  output logic                         S_AXI_RVALID,
  input  logic                         S_AXI_RREADY,
  output logic [NUM_REGS*DATA_W-1:0]   reg_q,
  input  logic [NUM_REGS*DATA_W-1:0]   ro_in,
  output logic                         wr_pulse,
  output logic [((NUM_REGS > 1) ? $clog2(NUM_REGS) : 1)-1:0] wr_idx
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);
  localparam int unsigned IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned ADDR_X = ADDR_W + 1;
  localparam logic [ADDR_W:0] NREGS_A = ADDR_X'(NUM_REGS);

  // Reset: asserts immediately, releases two edges after aresetn rises.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  // Storage and slot views.
  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [DATA_W-1:0] w_ro   [NUM_REGS];

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_slot
    assign w_ro[g]                   = ro_in[g*DATA_W +: DATA_W];
    assign reg_q[g*DATA_W +: DATA_W] = RO_MASK[g] ? '0 : r_regs[g];
  end

  // ---------------------------------------------------------------- write path
  wstate_t           r_wstate;
  logic              r_awready;
  logic              r_wready;
  logic              r_bvalid;
  resp_t             r_bresp;
  logic [ADDR_W-1:0] r_aw_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [STRB_W-1:0] r_wstrb;
  logic              r_wr_pulse;
  logic [IDX_W-1:0]  r_wr_idx;

  logic              w_aw_hs;
  logic              w_w_hs;
  logic              w_commit;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [ADDR_W-1:0] w_wr_slot;
  logic [DATA_W-1:0] w_wr_data;
  logic [STRB_W-1:0] w_wr_strb;
  logic              w_wr_in_range;
  logic [IDX_W-1:0]  w_wr_idx;
  logic              w_wr_ok;
  logic [DATA_W-1:0] w_merged;

  assign w_aw_hs = S_AXI_AWVALID & r_awready;
  assign w_w_hs  = S_AXI_WVALID  & r_wready;

  // Commit uses the held half of the transaction and the live half arriving now.
  always_comb begin
    w_commit  = 1'b0;
    w_wr_addr = (r_wstate == W_HAVE_AW) ? r_aw_addr : S_AXI_AWADDR;
    w_wr_data = (r_wstate == W_HAVE_W)  ? r_wdata   : S_AXI_WDATA;
    w_wr_strb = (r_wstate == W_HAVE_W)  ? r_wstrb   : S_AXI_WSTRB;
    case (r_wstate)
      W_IDLE:    w_commit = w_aw_hs & w_w_hs;
      W_HAVE_AW: w_commit = w_w_hs;
      W_HAVE_W:  w_commit = w_aw_hs;
      default:   w_commit = 1'b0;
    endcase
  end

  // Out-of-range indices are steered to slot 0 so the array is never over-indexed.
  assign w_wr_slot     = w_wr_addr >> OFF_W;
  assign w_wr_in_range = ({1'b0, w_wr_slot} < NREGS_A);
  assign w_wr_idx      = w_wr_in_range ? w_wr_slot[IDX_W-1:0] : '0;
  assign w_wr_ok       = w_wr_in_range & ~RO_MASK[w_wr_idx];

  axi4_lite_wstrb_merge #(
    .DATA_W (DATA_W)
  ) u_merge (
    .i_old      (r_regs[w_wr_idx]),
    .i_new      (w_wr_data),
    .i_strb     (w_wr_strb),
    .o_merged_c (w_merged)
  );

  // Write channel FSM with registered READY/VALID/RESP and write strobe.
  always_ff @(posedge aclk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_wstate   <= W_IDLE;
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
      r_aw_addr  <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_wr_pulse <= 1'b0;
      r_wr_idx   <= '0;
    end else begin
      r_wr_pulse <= 1'b0;
      if (w_aw_hs) r_aw_addr <= S_AXI_AWADDR;
      if (w_w_hs) begin
        r_wdata <= S_AXI_WDATA;
        r_wstrb <= S_AXI_WSTRB;
      end
      if (w_commit) begin
        r_wstate  <= W_RESP;
        r_awready <= 1'b0;
        r_wready  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= ok_resp(w_wr_ok);
        if (w_wr_ok) begin
          r_wr_pulse <= 1'b1;
          r_wr_idx   <= w_wr_idx;
        end
      end else begin
        case (r_wstate)
          W_IDLE: begin
            if (w_aw_hs) begin
              r_wstate  <= W_HAVE_AW;
              r_awready <= 1'b0;
              r_wready  <= 1'b1;
            end else if (w_w_hs) begin
              r_wstate  <= W_HAVE_W;
              r_awready <= 1'b1;
              r_wready  <= 1'b0;
            end else begin
              r_awready <= 1'b1;
              r_wready  <= 1'b1;
            end
          end
          W_HAVE_AW, W_HAVE_W: begin
            // waiting for the other half of the write
          end
          W_RESP: begin
            if (S_AXI_BREADY) begin
              r_wstate  <= W_IDLE;
              r_bvalid  <= 1'b0;
              r_awready <= 1'b1;
              r_wready  <= 1'b1;
            end
          end
          default: r_wstate <= W_IDLE;
        endcase
      end
    end
  end

  // Register array; RO slots are never written and stay at their reset value.
  always_ff @(posedge aclk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_commit && w_wr_ok) begin
      r_regs[w_wr_idx] <= w_merged;
    end
  end

  // ----------------------------------------------------------------- read path
  rstate_t           r_rstate;
  logic              r_arready;
  logic              r_rvalid;
  resp_t             r_rresp;
  logic [DATA_W-1:0] r_rdata;

  logic              w_ar_hs;
  logic [ADDR_W-1:0] w_rd_slot;
  logic              w_rd_in_range;
  logic [IDX_W-1:0]  w_rd_idx;
  logic [DATA_W-1:0] w_rd_data;

  assign w_ar_hs       = S_AXI_ARVALID & r_arready;
  assign w_rd_slot     = S_AXI_ARADDR >> OFF_W;
  assign w_rd_in_range = ({1'b0, w_rd_slot} < NREGS_A);
  assign w_rd_idx      = w_rd_in_range ? w_rd_slot[IDX_W-1:0] : '0;
  assign w_rd_data     = !w_rd_in_range     ? '0 :
                         RO_MASK[w_rd_idx]  ? w_ro[w_rd_idx] : r_regs[w_rd_idx];

  // Read channel FSM; data is captured from the pre-edge register value.
  always_ff @(posedge aclk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rdata   <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_rstate  <= R_RESP;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b1;
            r_rdata   <= w_rd_data;
            r_rresp   <= ok_resp(w_rd_in_range);
          end else begin
            r_arready <= 1'b1;
          end
        end
        R_RESP: begin
          if (S_AXI_RREADY) begin
            r_rstate  <= R_IDLE;
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  // Protection attributes carry no meaning for this block.
  logic w_unused;
  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT};

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_wready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RRESP   = r_rresp;
  assign S_AXI_RDATA   = r_rdata;
  assign wr_pulse      = r_wr_pulse;
  assign wr_idx        = r_wr_idx;

endmodule

// File: tb/tb_axi4_lite_regfile.sv
// Directed bench for axi4_lite_regfile (32-bit data, 16 regs, reg 3 read-only).
`timescale 1ns/1ps
module tb_axi4_lite_regfile;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 12;
  localparam int unsigned NUM_REGS = 16;
  localparam logic [NUM_REGS-1:0] RO_MASK = 16'h0008;

  logic                       aclk = 1'b0;
  logic                       aresetn = 1'b0;
  logic [ADDR_W-1:0]          S_AXI_AWADDR = '0;
  logic [2:0]                 S_AXI_AWPROT = 3'b000;
  logic                       S_AXI_AWVALID = 1'b0;
  logic                       S_AXI_AWREADY;
  logic [DATA_W-1:0]          S_AXI_WDATA = '0;
  logic [DATA_W/8-1:0]        S_AXI_WSTRB = '0;
  logic                       S_AXI_WVALID = 1'b0;
  logic                       S_AXI_WREADY;
  logic [1:0]                 S_AXI_BRESP;
  logic                       S_AXI_BVALID;
  logic                       S_AXI_BREADY = 1'b0;
  logic [ADDR_W-1:0]          S_AXI_ARADDR = '0;
  logic [2:0]                 S_AXI_ARPROT = 3'b000;
  logic                       S_AXI_ARVALID = 1'b0;
  logic                       S_AXI_ARREADY;
  logic [DATA_W-1:0]          S_AXI_RDATA;
  logic [1:0]                 S_AXI_RRESP;
  logic                       S_AXI_RVALID;
  logic                       S_AXI_RREADY = 1'b0;
  logic [NUM_REGS*DATA_W-1:0] reg_q;
  logic [NUM_REGS*DATA_W-1:0] ro_in = '0;
  logic                       wr_pulse;
  logic [3:0]                 wr_idx;

  axi4_lite_regfile #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS),
    .RO_MASK  (RO_MASK)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWPROT  (S_AXI_AWPROT),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARPROT  (S_AXI_ARPROT),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY),
    .reg_q         (reg_q),
    .ro_in         (ro_in),
    .wr_pulse      (wr_pulse),
    .wr_idx        (wr_idx)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] slot(input int i);
    return reg_q[i*32 +: 32];
  endfunction

  function automatic logic [63:0] out_vec();
    return 64'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP,
                S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RRESP, S_AXI_RDATA,
                wr_pulse, wr_idx});
  endfunction

  // Drive AW/W with independent delays, then take the response.
  // Returns BVALID/BRESP/wr_pulse/wr_idx as seen just after the final handshake.
  task automatic do_write(input logic [11:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_dly, input int w_dly,
                          output logic bv, output logic [1:0] resp,
                          output logic pulse, output logic [3:0] idx);
    bit aw_done, w_done, hs_aw, hs_w, hs_b;
    int cyc;
    aw_done = 0; w_done = 0; cyc = 0;
    S_AXI_AWADDR  = addr;
    S_AXI_WDATA   = data;
    S_AXI_WSTRB   = strb;
    S_AXI_AWVALID = (aw_dly == 0);
    S_AXI_WVALID  = (w_dly == 0);
    while (!(aw_done && w_done) && cyc < 40) begin
      @(negedge aclk);
      hs_aw = S_AXI_AWVALID && S_AXI_AWREADY;
      hs_w  = S_AXI_WVALID && S_AXI_WREADY;
      @(posedge aclk); #1;
      if (hs_aw) begin aw_done = 1; S_AXI_AWVALID = 1'b0; end
      if (hs_w)  begin w_done = 1;  S_AXI_WVALID  = 1'b0; end
      cyc++;
      if (!aw_done && cyc >= aw_dly) S_AXI_AWVALID = 1'b1;
      if (!w_done && cyc >= w_dly)   S_AXI_WVALID  = 1'b1;
    end
    check_eq("wr_handshakes", {aw_done, w_done}, 2'b11);
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    bv = S_AXI_BVALID; resp = S_AXI_BRESP; pulse = wr_pulse; idx = wr_idx;
    S_AXI_BREADY = 1'b1;
    cyc = 0;
    do begin
      @(negedge aclk); hs_b = S_AXI_BVALID;
      @(posedge aclk); #1; cyc++;
    end while (!hs_b && cyc < 20);
    S_AXI_BREADY = 1'b0;
  endtask

  task automatic do_read(input logic [11:0] addr, output logic [31:0] data, output logic [1:0] resp);
    bit hs;
    int cyc;
    cyc = 0;
    S_AXI_ARADDR  = addr;
    S_AXI_ARVALID = 1'b1;
    do begin
      @(negedge aclk); hs = S_AXI_ARREADY;
      @(posedge aclk); #1; cyc++;
    end while (!hs && cyc < 20);
    S_AXI_ARVALID = 1'b0;
    check_eq("rd_hs_rvalid", {hs, S_AXI_RVALID}, 2'b11);
    data = S_AXI_RDATA; resp = S_AXI_RRESP;
    S_AXI_RREADY = 1'b1;
    @(posedge aclk); #1;
    S_AXI_RREADY = 1'b0;
  endtask

  // Wait (bounded) for all three address/data READYs after reset release.
  task automatic wait_ready(input string tag);
    int cyc;
    cyc = 0;
    while (!(S_AXI_AWREADY && S_AXI_WREADY && S_AXI_ARREADY) && cyc < 8) begin
      @(posedge aclk); #1; cyc++;
    end
    check_eq(tag, {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID}, 5'b11100);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic       bv, pl, ok, stable;
    logic [1:0] rs;
    logic [3:0] ix;
    logic [31:0] rd;

    for (int i = 0; i < NUM_REGS; i++) ro_in[i*32 +: 32] = 32'h5A00_0000 | 32'(i);
    ro_in[3*32 +: 32] = 32'hCAFE_0001;

    // Reset state
    #22;
    check_eq("rst_outputs", out_vec(), 64'h0);
    check_eq("rst_reg_q", 64'(|reg_q), 64'h0);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;
    check_eq("ready_not_first_edge", 64'(S_AXI_ARREADY), 64'h0);
    wait_ready("rst_release_ready");

    // AW first, W three cycles later
    do_write(12'h008, 32'hDEADBEEF, 4'hF, 0, 3, bv, rs, pl, ix);
    check_eq("w35_bvalid", 64'(bv), 64'h1);
    check_eq("w35_bresp", 64'(rs), 64'h0);
    check_eq("w35_pulse_idx", {pl, ix}, {1'b1, 4'd2});
    check_eq("w35_reg2", slot(2), 32'hDEADBEEF);

    // Byte-strobe merge, both channels in the same cycle
    do_write(12'h004, 32'h11223344, 4'hF, 0, 0, bv, rs, pl, ix);
    check_eq("w36a_bv_resp_pulse", {bv, rs, pl, ix}, {1'b1, 2'b00, 1'b1, 4'd1});
    do_write(12'h004, 32'hAABBCCDD, 4'h5, 0, 0, bv, rs, pl, ix);
    check_eq("w36b_reg1", slot(1), 32'h11BB33DD);
    do_read(12'h006, rd, rs);
    check_eq("r36_offset_read", {rs, rd}, {2'b00, 32'h11BB33DD});

    // Zero strobe: OKAY, pulse, no change
    do_write(12'h004, 32'hFFFFFFFF, 4'h0, 0, 0, bv, rs, pl, ix);
    check_eq("wstrb0_resp_pulse", {bv, rs, pl, ix}, {1'b1, 2'b00, 1'b1, 4'd1});
    check_eq("wstrb0_reg1", slot(1), 32'h11BB33DD);

    // W first, AW two cycles later
    do_write(12'h01C, 32'h12345678, 4'hF, 2, 0, bv, rs, pl, ix);
    check_eq("wfirst_resp_pulse", {bv, rs, pl, ix}, {1'b1, 2'b00, 1'b1, 4'd7});
    do_read(12'h01C, rd, rs);
    check_eq("wfirst_readback", {rs, rd}, {2'b00, 32'h12345678});

    // Out of range
    do_read(12'h040, rd, rs);
    check_eq("oor_read", {rs, rd}, {2'b10, 32'h0});
    do_write(12'h040, 32'h55555555, 4'hF, 0, 0, bv, rs, pl, ix);
    check_eq("oor_write", {bv, rs, pl}, {1'b1, 2'b10, 1'b0});
    check_eq("oor_regs_kept", {slot(0), slot(2)}, {32'h0, 32'hDEADBEEF});

    // Read-only register
    do_read(12'h00C, rd, rs);
    check_eq("ro_read", {rs, rd}, {2'b00, 32'hCAFE0001});
    do_write(12'h00C, 32'h77777777, 4'hF, 0, 0, bv, rs, pl, ix);
    check_eq("ro_write", {bv, rs, pl}, {1'b1, 2'b10, 1'b0});
    check_eq("ro_slot_zero", slot(3), 32'h0);

    // Read and write commit of reg 5 on the same edge
    S_AXI_AWADDR = 12'h014; S_AXI_WDATA = 32'h0000FFFF; S_AXI_WSTRB = 4'hF;
    S_AXI_ARADDR = 12'h014;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
    @(negedge aclk);
    ok = S_AXI_AWREADY && S_AXI_WREADY && S_AXI_ARREADY;
    @(posedge aclk); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    check_eq("same_edge_ready", 64'(ok), 64'h1);
    check_eq("same_edge_rdata", {S_AXI_RVALID, S_AXI_RRESP, S_AXI_RDATA}, {1'b1, 2'b00, 32'h0});
    check_eq("same_edge_commit", {S_AXI_BVALID, wr_pulse, wr_idx, slot(5)}, {1'b1, 1'b1, 4'd5, 32'h0000FFFF});
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
    @(posedge aclk); #1;
    S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
    do_read(12'h014, rd, rs);
    check_eq("same_edge_followup", {rs, rd}, {2'b00, 32'h0000FFFF});

    // Hold BREADY low on a rejected write, then reset mid-hold
    S_AXI_AWADDR = 12'h00C; S_AXI_WDATA = 32'h13579BDF; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    @(posedge aclk); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge aclk);
      if (!(S_AXI_BVALID === 1'b1 && S_AXI_BRESP === 2'b10 &&
            S_AXI_AWREADY === 1'b0 && S_AXI_WREADY === 1'b0)) stable = 1'b0;
    end
    check_eq("bhold_stable", 64'(stable), 64'h1);
    aresetn = 1'b0;
    #1;
    check_eq("midrst_outputs", out_vec(), 64'h0);
    check_eq("midrst_reg_q", 64'(|reg_q), 64'h0);
    @(posedge aclk); @(posedge aclk); #1;
    aresetn = 1'b1;
    wait_ready("midrst_idle");
    do_read(12'h008, rd, rs);
    check_eq("post_rst_reg2", {rs, rd}, {2'b00, 32'h0});
    do_write(12'h03C, 32'hA5A5A5A5, 4'hF, 0, 0, bv, rs, pl, ix);
    check_eq("post_rst_write", {bv, rs, pl, ix, slot(15)}, {1'b1, 2'b00, 1'b1, 4'd15, 32'hA5A5A5A5});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
